data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter LOCK_MAX, 8: maximum consecutive requester-1 grants while locked (range 1..255).
REQ-002 Parameter CNT_W, 16: width of each saturating grant counter.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
REQ-005 r0_valid, r1_valid  in  1  request present (r0 = CPU data port, r1 = loader/debug port).
REQ-006 r0_ready, r1_ready  out  1  grant this cycle; handshake = valid & ready.
REQ-007 r0_we, r1_we  in  1  1 = write, 0 = read.
REQ-008 r0_addr, r1_addr  in  32  byte address, passed unmodified to memory.
REQ-009 r0_wdata, r1_wdata  in  32  write data.
REQ-010 r1_lock  in  1  requester 1 requests bus lock for a burst.
REQ-011 r0_rvalid, r1_rvalid  out  1  one-cycle pulse: read data valid.
REQ-012 r0_rdata, r1_rdata  out  32  registered read data.
REQ-013 mem_addr  out  32; mem_wdata  out  32; mem_we  out  1  shared memory port.
REQ-014 mem_rdata  in  32  combinational read data for mem_addr.
REQ-015 grant_count0, grant_count1  out  CNT_W  saturating handshake counts.
REQ-016 locked  out  1  FSM in ARB_LOCKED.

Function
REQ-017 At most one of r0_ready/r1_ready SHALL be high per cycle; ready SHALL depend only on valids, r1_lock-derived state and registered state (combinational, zero latency).
REQ-018 ARB_IDLE: single valid requester SHALL be granted; both valid -> grant the requester not granted last (register last_grant).
REQ-019 last_grant SHALL update to the handshaking requester on every handshake.
REQ-020 mem_addr/mem_wdata SHALL follow the granted requester (requester 0 when none granted); mem_we = granted we & handshake.
REQ-021 Read handshake in cycle N SHALL capture mem_rdata into rX_rdata at the end of N and pulse rX_rvalid in N+1 only; rX_rdata SHALL hold until the next read response for that port.
REQ-022 Back-to-back handshakes SHALL be accepted every cycle (throughput 1/cycle, no bubble).
REQ-023 ARB_IDLE -> ARB_LOCKED on r1 handshake with r1_lock = 1; lock counter loads 1.
REQ-024 ARB_LOCKED: r0_ready = 0; r1_ready = r1_valid; each r1 handshake increments the lock counter.
REQ-025 ARB_LOCKED -> ARB_IDLE when r1_lock = 0 (sampled at the clock edge, regardless of r1_valid), or on the r1 handshake that makes the lock counter equal LOCK_MAX; on exit last_grant = 1 so r0 wins the next tie.
REQ-026 On forced exit (LOCK_MAX) the FSM SHALL NOT re-enter ARB_LOCKED until one r0 handshake has occurred or r0_valid is low in ARB_IDLE.
REQ-027 Grant counters SHALL increment per handshake and saturate at all-ones.
REQ-028 Requester dropping valid without handshake SHALL cause no state change.

Reset
REQ-029 While reset = 0: state ARB_IDLE, last_grant = 1, lock counter 0, ready outputs 0, mem_we 0, rvalid 0, rdata 0, grant counters 0, locked 0.
REQ-030 Reset asserted mid-burst or with a read pending SHALL drop the pending rvalid and return to ARB_IDLE in one cycle.

Structure
REQ-031 arb_state_t {ARB_IDLE, ARB_LOCKED} SHALL live in the shared package with the other CPU enums.
REQ-032 One sub-module sat_counter (parameter width, inc, synchronous active-low clear) SHALL implement both grant counters.

Verification
REQ-033 Both valid, reads, after reset -> r0 granted cycle 1, r1 cycle 2, alternating; rvalid pulses one cycle later with matching mem_rdata.
REQ-034 r0 write addr 0x8 data 0xDEADBEEF -> mem_we = 1 same cycle, mem_addr 0x8; no rvalid.
REQ-035 r1_lock = 1, r1 and r0 continuously valid, LOCK_MAX = 8 -> 8 r1 grants, locked deasserts, next grant r0.
REQ-036 r1_lock dropped after 3 locked grants -> ARB_IDLE next cycle; r0 granted on next tie.
REQ-037 reset low during locked burst with read pending -> next cycle all outputs at reset values, rvalid not asserted.
REQ-038 CNT_W = 4, 20 r0 handshakes -> grant_count0 = 15 and holds.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the CPU data-memory arbiter: FSM state and request enums.
package data_memory_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Two requester ports plus the shared memory port of the data-memory arbiter.
interface data_memory_arbiter_if;
  import data_memory_arbiter_pkg::*;

  // Handshake: a transfer occurs in any cycle where rX_valid & rX_ready are both high;
  // ready is combinational from valid and registered state, and valid may drop freely.
  logic              r0_valid;
  logic              r0_ready;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_valid;
  logic              r1_ready;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_lock;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata, r1_lock,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata, r1_lock,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/data_memory_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port data-memory arbiter: round-robin on ties, optional bounded bus lock for requester 1.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]      grant_count0,
  output logic [CNT_W-1:0]      grant_count1,
  output logic                  locked,
  output arb_state_t            state_dbg
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  arb_state_t state;
  logic       last_grant;
  logic [7:0] lock_cnt;
  logic [7:0] lock_next;
  logic       no_relock;
  logic       gnt0;
  logic       gnt1;

  // A grant is only ever given to a valid requester, so grant == handshake.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (state == ARB_LOCKED) begin
        gnt1 = bus.r1_valid;
      end else if (bus.r0_valid && bus.r1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = bus.r0_valid;
        gnt1 = bus.r1_valid;
      end
    end
  end

  assign bus.r0_ready  = gnt0;
  assign bus.r1_ready  = gnt1;
  assign bus.mem_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
  assign bus.mem_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;
  assign bus.mem_we    = (gnt1 & bus.r1_we) | (gnt0 & bus.r0_we);
  assign lock_next     = lock_cnt + 8'd1;
  assign locked        = (state == ARB_LOCKED);
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      last_grant    <= 1'b1;
      lock_cnt      <= 8'd0;
      no_relock     <= 1'b0;
      bus.r0_rvalid <= 1'b0;
      bus.r1_rvalid <= 1'b0;
      bus.r0_rdata  <= '0;
      bus.r1_rdata  <= '0;
    end else begin
      bus.r0_rvalid <= gnt0 & !bus.r0_we;
      bus.r1_rvalid <= gnt1 & !bus.r1_we;
      if (gnt0 && !bus.r0_we) bus.r0_rdata <= bus.mem_rdata;
      if (gnt1 && !bus.r1_we) bus.r1_rdata <= bus.mem_rdata;
      if (gnt0) last_grant <= 1'b0;
      if (gnt1) last_grant <= 1'b1;

      case (state)
        ARB_IDLE: begin
          if (gnt0 || !bus.r0_valid) no_relock <= 1'b0;
          if (gnt1 && bus.r1_lock && (!no_relock || !bus.r0_valid)) begin
            // With LOCK_MAX of 1 the entering grant already exhausts the burst.
            if (LOCK_MAX_C == 8'd1) begin
              no_relock <= 1'b1;
            end else begin
              state    <= ARB_LOCKED;
              lock_cnt <= 8'd1;
            end
          end
        end
        ARB_LOCKED: begin
          if (gnt1) lock_cnt <= lock_next;
          if (gnt1 && (lock_next == LOCK_MAX_C)) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            no_relock  <= 1'b1;
          end else if (!bus.r1_lock) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt0 (
    .clk     (clk),
    .clear_n (reset),
    .inc     (gnt0),
    .count   (grant_count0)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt1 (
    .clk     (clk),
    .clear_n (reset),
    .inc     (gnt1),
    .count   (grant_count1)
  );

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: main instance plus a CNT_W=4 instance for saturation.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  data_memory_arbiter_if bus();
  data_memory_arbiter_if bus_s();

  // Memory model: read data is a fixed function of the address.
  assign bus.mem_rdata   = bus.mem_addr ^ K;
  assign bus_s.mem_rdata = bus_s.mem_addr ^ K;

  logic [15:0] gc0, gc1;
  logic        lk;
  arb_state_t  st;
  logic [3:0]  sgc0, sgc1;
  logic        slk;
  arb_state_t  sst;

  data_memory_arbiter #(.LOCK_MAX(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .grant_count0(gc0), .grant_count1(gc1), .locked(lk), .state_dbg(st)
  );

  data_memory_arbiter #(.LOCK_MAX(8), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s.slave),
    .grant_count0(sgc0), .grant_count1(sgc1), .locked(slk), .state_dbg(sst)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.r0_valid = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_valid = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_lock = 0;
    bus_s.r0_valid = 0; bus_s.r0_we = 0; bus_s.r0_addr = '0; bus_s.r0_wdata = '0;
    bus_s.r1_valid = 0; bus_s.r1_we = 0; bus_s.r1_addr = '0; bus_s.r1_wdata = '0; bus_s.r1_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    bus.r0_valid = 1; bus.r1_valid = 1; bus.r0_we = 1;
    #1;
    total++; if (bus.r0_ready !== 1'b0) begin bad++; $display("FAIL rst_r0_ready got %b want 0", bus.r0_ready); end
    total++; if (bus.r1_ready !== 1'b0) begin bad++; $display("FAIL rst_r1_ready got %b want 0", bus.r1_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
    @(posedge clk); #1;
    total++; if (lk !== 1'b0) begin bad++; $display("FAIL rst_locked got %b want 0", lk); end
    total++; if (st !== ARB_IDLE) begin bad++; $display("FAIL rst_state got %0d want 0", st); end
    total++; if (gc0 !== 16'd0 || gc1 !== 16'd0) begin bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", gc0, gc1); end
    total++; if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got %b%b want 00", bus.r0_rvalid, bus.r1_rvalid); end
    total++; if (bus.r0_rdata !== 32'd0 || bus.r1_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got %h/%h want 0/0", bus.r0_rdata, bus.r1_rdata); end
    @(negedge clk);
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_alternate();
    logic [31:0] a0, a1, ea;
    logic        e0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a0 = 32'h100 + 32'(i * 4);
      a1 = 32'h200 + 32'(i * 4);
      bus.r0_valid = 1; bus.r1_valid = 1; bus.r0_we = 0; bus.r1_we = 0;
      bus.r0_addr = a0; bus.r1_addr = a1;
      e0 = (i % 2 == 0);
      ea = e0 ? a0 : a1;
      #1;
      total++; if (bus.r0_ready !== e0 || bus.r1_ready !== !e0) begin bad++; $display("FAIL alt_ready cyc%0d got %b%b want %b%b", i, bus.r0_ready, bus.r1_ready, e0, !e0); end
      total++; if (bus.mem_addr !== ea) begin bad++; $display("FAIL alt_mem_addr cyc%0d got %h want %h", i, bus.mem_addr, ea); end
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL alt_mem_we cyc%0d got %b want 0", i, bus.mem_we); end
      @(posedge clk); #1;
      total++; if (bus.r0_rvalid !== e0 || bus.r1_rvalid !== !e0) begin bad++; $display("FAIL alt_rvalid cyc%0d got %b%b want %b%b", i, bus.r0_rvalid, bus.r1_rvalid, e0, !e0); end
      total++; if ((e0 ? bus.r0_rdata : bus.r1_rdata) !== (ea ^ K)) begin bad++; $display("FAIL alt_rdata cyc%0d got %h want %h", i, e0 ? bus.r0_rdata : bus.r1_rdata, ea ^ K); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.r0_valid = 1; bus.r0_we = 1; bus.r0_addr = 32'h8; bus.r0_wdata = 32'hDEADBEEF;
    #1;
    total++; if (bus.r0_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got %b want 1", bus.r0_ready); end
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_we got %b want 1", bus.mem_we); end
    total++; if (bus.mem_addr !== 32'h8) begin bad++; $display("FAIL wr_mem_addr got %h want 8", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem_wdata got %h want deadbeef", bus.mem_wdata); end
    @(posedge clk); #1;
    total++; if (bus.r0_rvalid !== 1'b0) begin bad++; $display("FAIL wr_rvalid got %b want 0", bus.r0_rvalid); end
    total++; if (bus.r0_rdata !== (32'h110 ^ K)) begin bad++; $display("FAIL wr_rdata_hold got %h want %h", bus.r0_rdata, 32'h110 ^ K); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL wr_mem_we_idle got %b want 0", bus.mem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 32'h40 + 32'(i * 4);
      bus.r0_valid = 1; bus.r0_we = 0; bus.r0_addr = a;
      #1;
      total++; if (bus.r0_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc%0d got %b want 1", i, bus.r0_ready); end
      @(posedge clk); #1;
      total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== (a ^ K)) begin bad++; $display("FAIL b2b_rdata cyc%0d got %b/%h want 1/%h", i, bus.r0_rvalid, bus.r0_rdata, a ^ K); end
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    total++; if (bus.r0_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_pulse got %b want 0", bus.r0_rvalid); end
    total++; if (bus.r0_rdata !== (32'h4C ^ K)) begin bad++; $display("FAIL b2b_hold got %h want %h", bus.r0_rdata, 32'h4C ^ K); end
  endtask

  task automatic test_lock_max();
    logic e0, e1, el;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.r0_valid = 1; bus.r1_valid = 1; bus.r1_lock = 1;
      bus.r0_addr = 32'h300; bus.r1_addr = 32'h400 + 32'(i * 4);
      e0 = (i == 0 || i == 9);
      e1 = !e0;
      #1;
      total++; if (bus.r0_ready !== e0 || bus.r1_ready !== e1) begin bad++; $display("FAIL lockmax_ready cyc%0d got %b%b want %b%b", i, bus.r0_ready, bus.r1_ready, e0, e1); end
      @(posedge clk); #1;
      el = (i >= 1 && i <= 7) || (i == 10);
      total++; if (lk !== el) begin bad++; $display("FAIL lockmax_locked cyc%0d got %b want %b", i, lk, el); end
    end
    total++; if (gc0 !== 16'd2 || gc1 !== 16'd9) begin bad++; $display("FAIL lockmax_counts got %0d/%0d want 2/9", gc0, gc1); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock_drop();
    logic e0, e1, el;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.r0_valid = 1;
      bus.r1_valid = (i != 4);
      bus.r1_lock  = (i < 4);
      e0 = (i == 0 || i == 5);
      e1 = (i >= 1 && i <= 3);
      #1;
      total++; if (bus.r0_ready !== e0 || bus.r1_ready !== e1) begin bad++; $display("FAIL lockdrop_ready cyc%0d got %b%b want %b%b", i, bus.r0_ready, bus.r1_ready, e0, e1); end
      @(posedge clk); #1;
      el = (i >= 1 && i <= 3);
      total++; if (lk !== el) begin bad++; $display("FAIL lockdrop_locked cyc%0d got %b want %b", i, lk, el); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.r0_valid = 1; bus.r1_valid = 1; bus.r1_lock = 1;
      bus.r0_addr = 32'h500; bus.r1_addr = 32'h600;
    end
    @(posedge clk); #1;
    total++; if (lk !== 1'b1 || bus.r1_rvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre got locked=%b rvalid=%b want 1/1", lk, bus.r1_rvalid); end
    @(negedge clk);
    reset = 0;
    #1;
    total++; if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got %b%b want 00", bus.r0_ready, bus.r1_ready); end
    @(posedge clk); #1;
    total++; if (lk !== 1'b0 || st !== ARB_IDLE) begin bad++; $display("FAIL midrst_state got locked=%b state=%0d want 0/0", lk, st); end
    total++; if (bus.r1_rvalid !== 1'b0 || bus.r0_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got %b%b want 00", bus.r0_rvalid, bus.r1_rvalid); end
    total++; if (bus.r1_rdata !== 32'd0 || gc1 !== 16'd0 || gc0 !== 16'd0) begin bad++; $display("FAIL midrst_regs got rdata=%h gc0=%0d gc1=%0d want 0", bus.r1_rdata, gc0, gc1); end
    @(negedge clk);
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_saturate();
    logic [3:0] exp_c;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      bus_s.r0_valid = 1; bus_s.r0_addr = 32'(i * 4);
      @(posedge clk); #1;
      exp_c = (i >= 14) ? 4'd15 : 4'(i + 1);
      if (i == 13 || i == 14 || i == 19 || i == 21) begin
        total++; if (sgc0 !== exp_c) begin bad++; $display("FAIL sat_count cyc%0d got %0d want %0d", i, sgc0, exp_c); end
      end
    end
    total++; if (sgc1 !== 4'd0 || slk !== 1'b0 || sst !== ARB_IDLE) begin bad++; $display("FAIL sat_other got gc1=%0d locked=%b state=%0d want 0/0/0", sgc1, slk, sst); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alternate();
    test_write();
    test_back_to_back();
    test_lock_max();
    test_lock_drop();
    test_reset_mid_burst();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
